// File: rtl/dkong_rom_sched.sv
// Shared ROM time-division scheduler: a 16-slot wheel locked to the H counter. It multiplexes
// the ROM address between the requesters and runs the power-up config copy into the internal RAMs.
module dkong_rom_sched #(
    parameter logic [12:0] CNF_LAST  = 13'h1300,
    parameter bit          SYNC_LOCK = 1'b1
) (
    input  logic        W_CLK_12288M,
    input  logic        W_RESETn,
    input  logic        I_SYNC,
    input  logic [15:0] I_CPU_A,
    input  logic [18:0] I_WAV_A,
    input  logic [11:0] I_VID_A,
    input  logic [11:0] I_OBJ_A,
    input  logic [7:0]  I_ROM_D,
    output logic [18:0] O_ROM_A,
    output logic [7:0]  O_CPU_D,
    output logic [7:0]  O_WAV_D,
    output logic [7:0]  O_VID1_D,
    output logic [7:0]  O_VID2_D,
    output logic [7:0]  O_OBJ1_D,
    output logic [7:0]  O_OBJ2_D,
    output logic [7:0]  O_OBJ3_D,
    output logic [7:0]  O_OBJ4_D,
    output logic        O_CNF_EN,
    output logic [12:0] O_CNF_A,
    output logic [4:0]  O_CNF_WE,
    output logic [3:0]  O_PHASE,
    output logic        O_SYNC_ERR
);

    logic        r_sync_s0;
    logic        r_sync_s1;
    logic        r_lock;
    logic        r_sync_err;
    logic [3:0]  r_phase;
    logic [12:0] r_cnf_a;
    logic [18:0] r_rom_a;
    logic [18:0] w_rom_a_next;
    logic [7:0]  r_cpu_d;
    logic [7:0]  r_wav_d;
    logic [7:0]  r_vid1_d;
    logic [7:0]  r_vid2_d;
    logic [7:0]  r_obj1_d;
    logic [7:0]  r_obj2_d;
    logic [7:0]  r_obj3_d;
    logic [7:0]  r_obj4_d;
    logic [4:0]  r_cnf_we;
    logic [4:0]  w_we_dec;
    logic        w_sync_edge;
    logic        w_cnf_en;

    assign w_sync_edge = r_sync_s0 & ~r_sync_s1;
    assign w_cnf_en    = (r_cnf_a != CNF_LAST);

    // Target RAM decode from the config counter: two 2 KB sound images, then 256 B colour/VRAM pages
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_snd_we
            assign w_we_dec[gi] = w_cnf_en && (r_cnf_a[12:11] == 2'(gi));
        end
        for (gi = 0; gi < 3; gi++) begin : g_page_we
            assign w_we_dec[gi + 2] = w_cnf_en && (r_cnf_a[12:8] == 5'(16 + gi));
        end
    endgenerate

    always_comb begin
        w_rom_a_next = r_rom_a;
        case (r_phase)
            4'd0:                          w_rom_a_next = I_WAV_A;
            4'd2, 4'd5, 4'd8, 4'd11, 4'd15: w_rom_a_next = {3'h0, I_CPU_A};
            4'd3:                          w_rom_a_next = {3'h0, 4'h6, I_VID_A};
            4'd4:                          w_rom_a_next = w_cnf_en ? {6'b000111, r_cnf_a}
                                                                   : {3'h0, 4'h7, I_VID_A};
            4'd9:                          w_rom_a_next = {3'h0, 4'hA, I_OBJ_A};
            4'd10:                         w_rom_a_next = {3'h0, 4'hB, I_OBJ_A};
            4'd12:                         w_rom_a_next = {3'h0, 4'hC, I_OBJ_A};
            4'd13:                         w_rom_a_next = {3'h0, 4'hD, I_OBJ_A};
            default:                       w_rom_a_next = r_rom_a;
        endcase
    end

    always_ff @(posedge W_CLK_12288M or negedge W_RESETn) begin
        if (!W_RESETn) begin
            r_sync_s0  <= 1'b0;
            r_sync_s1  <= 1'b0;
            r_lock     <= 1'b0;
            r_sync_err <= 1'b0;
            r_phase    <= 4'd0;
            r_cnf_a    <= 13'd0;
            r_cnf_we   <= 5'd0;
        end else begin
            r_sync_s0 <= I_SYNC;
            r_sync_s1 <= r_sync_s0;
            if (w_sync_edge) begin
                r_lock <= 1'b1;
                if (r_lock && (r_phase != 4'hF)) begin
                    r_sync_err <= 1'b1;
                end
                if (SYNC_LOCK || !r_lock) begin
                    r_phase <= 4'd0;
                end else begin
                    r_phase <= r_phase + 4'd1;
                end
            end else begin
                r_phase <= r_phase + 4'd1;
            end
            if ((r_phase == 4'hF) && w_cnf_en) begin
                r_cnf_a <= r_cnf_a + 13'd1;
            end
            // Strobe lands in slot 15: O_VID2_D already holds this step's byte and the counter is stable
            r_cnf_we <= (r_phase == 4'hE) ? w_we_dec : 5'd0;
        end
    end

    // Each data latch fires at the end of the slot after its address was issued
    always_ff @(posedge W_CLK_12288M or negedge W_RESETn) begin
        if (!W_RESETn) begin
            r_rom_a  <= 19'd0;
            r_cpu_d  <= 8'd0;
            r_wav_d  <= 8'd0;
            r_vid1_d <= 8'd0;
            r_vid2_d <= 8'd0;
            r_obj1_d <= 8'd0;
            r_obj2_d <= 8'd0;
            r_obj3_d <= 8'd0;
            r_obj4_d <= 8'd0;
        end else begin
            r_rom_a <= w_rom_a_next;
            case (r_phase)
                4'd0, 4'd3, 4'd6, 4'd9, 4'd12: r_cpu_d <= I_ROM_D;
                4'd1:                          r_wav_d <= I_ROM_D;
                4'd4:                          r_vid1_d <= I_ROM_D;
                4'd5:                          r_vid2_d <= I_ROM_D;
                4'd10:                         r_obj1_d <= I_ROM_D;
                4'd11:                         r_obj2_d <= I_ROM_D;
                4'd13:                         r_obj3_d <= I_ROM_D;
                4'd14:                         r_obj4_d <= I_ROM_D;
                default: ;
            endcase
        end
    end

    assign O_ROM_A    = r_rom_a;
    assign O_CPU_D    = r_cpu_d;
    assign O_WAV_D    = r_wav_d;
    assign O_VID1_D   = r_vid1_d;
    assign O_VID2_D   = r_vid2_d;
    assign O_OBJ1_D   = r_obj1_d;
    assign O_OBJ2_D   = r_obj2_d;
    assign O_OBJ3_D   = r_obj3_d;
    assign O_OBJ4_D   = r_obj4_d;
    assign O_CNF_EN   = w_cnf_en;
    assign O_CNF_A    = r_cnf_a;
    assign O_CNF_WE   = r_cnf_we;
    assign O_PHASE    = r_phase;
    assign O_SYNC_ERR = r_sync_err;

endmodule

// File: tb/tb_dkong_rom_sched.sv
// Directed bench for dkong_rom_sched: H-counter sync source, ROM model returning A[7:0],
// slot address/data checks, full config copy, mid-copy reset and sync shift.
module tb_dkong_rom_sched;

    localparam logic [12:0] LAST = 13'h1300;

    logic        clk = 1'b0;
    logic        rstn;
    logic        sync;
    logic [15:0] cpu_a;
    logic [18:0] wav_a;
    logic [11:0] vid_a;
    logic [11:0] obj_a;
    logic [7:0]  rom_d = 8'h00;
    logic [18:0] rom_a;
    logic [7:0]  cpu_d, wav_d, vid1_d, vid2_d, obj1_d, obj2_d, obj3_d, obj4_d;
    logic        cnf_en;
    logic [12:0] cnf_a;
    logic [4:0]  cnf_we;
    logic [3:0]  phase;
    logic        sync_err;

    int          tests = 0;
    int          fails = 0;
    logic [3:0]  h;
    logic [3:0]  ph;
    logic [12:0] cnt_exp;

    dkong_rom_sched dut (
        .W_CLK_12288M (clk),
        .W_RESETn     (rstn),
        .I_SYNC       (sync),
        .I_CPU_A      (cpu_a),
        .I_WAV_A      (wav_a),
        .I_VID_A      (vid_a),
        .I_OBJ_A      (obj_a),
        .I_ROM_D      (rom_d),
        .O_ROM_A      (rom_a),
        .O_CPU_D      (cpu_d),
        .O_WAV_D      (wav_d),
        .O_VID1_D     (vid1_d),
        .O_VID2_D     (vid2_d),
        .O_OBJ1_D     (obj1_d),
        .O_OBJ2_D     (obj2_d),
        .O_OBJ3_D     (obj3_d),
        .O_OBJ4_D     (obj4_d),
        .O_CNF_EN     (cnf_en),
        .O_CNF_A      (cnf_a),
        .O_CNF_WE     (cnf_we),
        .O_PHASE      (phase),
        .O_SYNC_ERR   (sync_err)
    );

    initial forever #5 clk = ~clk;

    // ROM port B: registered on the falling edge, data equals the low address byte
    always @(negedge clk) rom_d <= rom_a[7:0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: ph is the slot the DUT is in now; then H advances and I_SYNC follows H[3:1]==7
    task automatic tick();
        @(negedge clk);
        ph = h + 4'd1;
        if ((ph == 4'd0) && (cnt_exp != LAST)) cnt_exp = cnt_exp + 13'd1;
        h = h + 4'd1;
        sync = (h[3:1] == 3'b111);
    endtask

    function automatic logic [4:0] we_of(input logic [12:0] c);
        if (c < 13'h0800)      return 5'b00001;
        else if (c < 13'h1000) return 5'b00010;
        else if (c < 13'h1100) return 5'b00100;
        else if (c < 13'h1200) return 5'b01000;
        else if (c < LAST)     return 5'b10000;
        else                   return 5'b00000;
    endfunction

    function automatic logic [18:0] addr_of(input logic [3:0] q);
        case (q)
            4'd1, 4'd2:   return 19'h45A5A;
            4'd4:         return 19'h060AB;
            4'd5:         return 19'h070AB;
            4'd10:        return 19'h0A0CD;
            4'd11:        return 19'h0B0CD;
            4'd13:        return 19'h0C0CD;
            4'd14, 4'd15: return 19'h0D0CD;
            default:      return 19'h01234;
        endcase
    endfunction

    initial begin
        cpu_a = 16'h1234; wav_a = 19'h45A5A; vid_a = 12'h0AB; obj_a = 12'h0CD;
        sync = 1'b0; h = 4'd0; ph = 4'd0; cnt_exp = 13'd0;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #1;
        chk("rst_rom_a", 32'(rom_a), 32'h0);
        chk("rst_cpu_d", 32'(cpu_d), 32'h0);
        chk("rst_vid2_d", 32'(vid2_d), 32'h0);
        chk("rst_obj4_d", 32'(obj4_d), 32'h0);
        chk("rst_cnf_en", 32'(cnf_en), 32'h1);
        chk("rst_cnf_a", 32'(cnf_a), 32'h0);
        chk("rst_cnf_we", 32'(cnf_we), 32'h0);
        chk("rst_phase", 32'(phase), 32'h0);
        chk("rst_sync_err", 32'(sync_err), 32'h0);

        repeat (3) @(negedge clk);
        rstn = 1'b1; h = 4'd0; sync = 1'b0;

        for (int k = 0; k < 48; k++) begin
            tick();
            chk("phase_run", 32'(phase), 32'(ph));
            chk("sync_err_run", 32'(sync_err), 32'h0);
        end
        chk("cpu_d", 32'(cpu_d), 32'h34);
        chk("wav_d", 32'(wav_d), 32'h5A);
        chk("vid1_d", 32'(vid1_d), 32'hAB);
        chk("obj1_d", 32'(obj1_d), 32'hCD);
        chk("obj2_d", 32'(obj2_d), 32'hCD);
        chk("obj3_d", 32'(obj3_d), 32'hCD);
        chk("obj4_d", 32'(obj4_d), 32'hCD);

        while ((cnt_exp != 13'h040) || (ph != 4'd8)) tick();
        chk("cnf_a_mid", 32'(cnf_a), 32'h040);
        chk("cnf_en_mid", 32'(cnf_en), 32'h1);

        #2 rstn = 1'b0;
        #1;
        chk("rst2_rom_a", 32'(rom_a), 32'h0);
        chk("rst2_cpu_d", 32'(cpu_d), 32'h0);
        chk("rst2_vid1_d", 32'(vid1_d), 32'h0);
        chk("rst2_obj1_d", 32'(obj1_d), 32'h0);
        chk("rst2_cnf_en", 32'(cnf_en), 32'h1);
        chk("rst2_cnf_a", 32'(cnf_a), 32'h0);
        chk("rst2_phase", 32'(phase), 32'h0);
        @(negedge clk);
        rstn = 1'b1; h = 4'd0; sync = 1'b0; cnt_exp = 13'd0;
        tick();
        chk("restart_cnf_a", 32'(cnf_a), 32'h0);
        chk("restart_phase", 32'(phase), 32'h1);

        for (int k = 0; k < 32'h1300 * 16 + 32; k++) begin
            tick();
            if (ph == 4'd0) begin
                chk("cnf_a", 32'(cnf_a), 32'(cnt_exp));
                chk("cnf_en", 32'(cnf_en), 32'(cnt_exp != LAST));
            end
            if (ph == 4'd5) begin
                chk("cnf_rom_a", 32'(rom_a),
                    (cnt_exp != LAST) ? 32'({6'b000111, cnt_exp}) : 32'h070AB);
            end
            if ((ph == 4'd6) && (cnt_exp != LAST)) begin
                chk("cnf_data", 32'(vid2_d), 32'(cnt_exp[7:0]));
            end
            if ((cnt_exp[7:0] == 8'hFF) || (cnt_exp[7:0] == 8'h00)) begin
                chk("cnf_we", 32'(cnf_we), (ph == 4'd15) ? 32'(we_of(cnt_exp)) : 32'h0);
            end
        end
        chk("cnf_done_en", 32'(cnf_en), 32'h0);
        chk("cnf_done_a", 32'(cnf_a), 32'(LAST));

        for (int k = 0; k < 16; k++) begin
            tick();
            chk("slot_addr", 32'(rom_a), 32'(addr_of(ph)));
            if (ph == 4'd15) chk("we_after_done", 32'(cnf_we), 32'h0);
        end
        chk("vid1_done", 32'(vid1_d), 32'hAB);
        chk("vid2_done", 32'(vid2_d), 32'hAB);
        chk("obj4_done", 32'(obj4_d), 32'hCD);

        cpu_a = 16'hBEEF; wav_a = 19'h00077;
        for (int k = 0; k < 32; k++) begin
            tick();
            if (ph == 4'd3) chk("cpu_addr2", 32'(rom_a), 32'h0BEEF);
        end
        chk("cpu_d2", 32'(cpu_d), 32'hEF);
        chk("wav_d2", 32'(wav_d), 32'h77);
        chk("sync_err_pre", 32'(sync_err), 32'h0);

        h = h + 4'd3;
        sync = (h[3:1] == 3'b111);
        repeat (20) tick();
        chk("sync_err_set", 32'(sync_err), 32'h1);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("phase_realign", 32'(phase), 32'(ph));
        end
        chk("sync_err_sticky", 32'(sync_err), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
